// File: rtl/bls12_381_pkg.sv
// BLS12-381 G1 shared types: Jacobian points, Fp helpers, point ops.
// Point ops double as the reference model for the sequencer bench.
package bls12_381_pkg;

    localparam int FP_BITS = 381;

    typedef logic [FP_BITS-1:0] fp_t;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } jb_point_t;

    localparam fp_t FP_P = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

    localparam jb_point_t INF = '0;

    localparam jb_point_t G1_GEN = {
        381'h17f1d3a73197d7942695638c4fa9ac0fc3688c4f9774b905a14e3a3f171bac586c55e83ff97a1aeffb3af00adb22c6bb,
        381'h08b3f481e3aaa0f1a09e30ed741d8ae4fcf5e095d5d00af600db18cb2c04b3edd03cc744a2888ae40caa232946c5e7e1,
        381'h1
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } pm_state_e;

    function automatic logic is_inf(input jb_point_t p);
        return p.z == '0;
    endfunction

    function automatic fp_t fp_add(input fp_t a, input fp_t b);
        logic [FP_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, FP_P}) s = s - {1'b0, FP_P};
        return s[FP_BITS-1:0];
    endfunction

    function automatic fp_t fp_sub(input fp_t a, input fp_t b);
        return (a >= b) ? a - b
                        : fp_t'({1'b0, a} + {1'b0, FP_P} - {1'b0, b});
    endfunction

    function automatic fp_t fp_mul(input fp_t a, input fp_t b);
        logic [2*FP_BITS-1:0] t;
        t = {{FP_BITS{1'b0}}, a} * {{FP_BITS{1'b0}}, b};
        return fp_t'(t % {{FP_BITS{1'b0}}, FP_P});
    endfunction

    // a = 0 doubling (dbl-2009-l)
    function automatic jb_point_t dbl_jb_point(input jb_point_t p);
        fp_t a, b, c, c8, d, e, f, x3, y3, z3;
        jb_point_t q;
        if (is_inf(p)) begin
            q = INF;
        end else begin
            a  = fp_mul(p.x, p.x);
            b  = fp_mul(p.y, p.y);
            c  = fp_mul(b, b);
            d  = fp_add(p.x, b);
            d  = fp_sub(fp_sub(fp_mul(d, d), a), c);
            d  = fp_add(d, d);
            e  = fp_add(fp_add(a, a), a);
            f  = fp_mul(e, e);
            x3 = fp_sub(f, fp_add(d, d));
            c8 = fp_add(c, c);
            c8 = fp_add(c8, c8);
            c8 = fp_add(c8, c8);
            y3 = fp_sub(fp_mul(e, fp_sub(d, x3)), c8);
            z3 = fp_mul(p.y, p.z);
            z3 = fp_add(z3, z3);
            q  = {x3, y3, z3};
        end
        return q;
    endfunction

    // add-2007-bl, falls back to doubling for equal inputs
    function automatic jb_point_t add_jb_point(input jb_point_t p1,
                                               input jb_point_t p2);
        fp_t z1z1, z2z2, u1, u2, s1, s2, h, hi, hj, rr, v, x3, y3, z3;
        jb_point_t q;
        if (is_inf(p1)) begin
            q = p2;
        end else if (is_inf(p2)) begin
            q = p1;
        end else begin
            z1z1 = fp_mul(p1.z, p1.z);
            z2z2 = fp_mul(p2.z, p2.z);
            u1   = fp_mul(p1.x, z2z2);
            u2   = fp_mul(p2.x, z1z1);
            s1   = fp_mul(fp_mul(p1.y, p2.z), z2z2);
            s2   = fp_mul(fp_mul(p2.y, p1.z), z1z1);
            if (u1 == u2) begin
                q = (s1 == s2) ? dbl_jb_point(p1) : INF;
            end else begin
                h  = fp_sub(u2, u1);
                hi = fp_add(h, h);
                hi = fp_mul(hi, hi);
                hj = fp_mul(h, hi);
                rr = fp_sub(s2, s1);
                rr = fp_add(rr, rr);
                v  = fp_mul(u1, hi);
                x3 = fp_sub(fp_sub(fp_mul(rr, rr), hj), fp_add(v, v));
                y3 = fp_mul(s1, hj);
                y3 = fp_sub(fp_mul(rr, fp_sub(v, x3)), fp_add(y3, y3));
                z3 = fp_add(p1.z, p2.z);
                z3 = fp_sub(fp_sub(fp_mul(z3, z3), z1z1), z2z2);
                z3 = fp_mul(z3, h);
                q  = {x3, y3, z3};
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/bls12_381_point_mult_ctrl.sv
// Right-to-left double-and-add sequencer for G1 scalar multiplication,
// issuing concurrent double/add requests to external point units.
module bls12_381_point_mult_ctrl
    import bls12_381_pkg::*;
#(
    parameter int SCALAR_BITS = 256
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [SCALAR_BITS-1:0] i_k,
    input  jb_point_t              i_p,
    input  logic                   i_val,
    output logic                   o_rdy,
    output jb_point_t              o_p,
    output logic                   o_val,
    input  logic                   i_rdy,
    output jb_point_t              o_dbl_p,
    output logic                   o_dbl_val,
    input  logic                   i_dbl_rdy,
    input  jb_point_t              i_dbl_p,
    input  logic                   i_dbl_val,
    output logic                   o_dbl_rdy,
    output jb_point_t              o_add_p1,
    output jb_point_t              o_add_p2,
    output logic                   o_add_val,
    input  logic                   i_add_rdy,
    input  jb_point_t              i_add_p,
    input  logic                   i_add_val,
    output logic                   o_add_rdy
);

    pm_state_e state, state_d;

    logic [SCALAR_BITS-1:0] k_q;
    jb_point_t              p_q;
    jb_point_t              r_q;

    logic need_dbl, need_add;
    logic got_dbl, got_add;
    logic dbl_req, add_req;

    logic [SCALAR_BITS-1:0] k_next;
    logic issue_stop, issue_dbl, issue_add;
    logic dbl_rsp, add_rsp, dbl_done, add_done, round_done;

    assign k_next     = k_q >> 1;
    assign issue_stop = (k_q == '0) || is_inf(p_q);
    assign issue_add  = k_q[0] & ~is_inf(r_q);
    assign issue_dbl  = (k_next != '0);

    assign dbl_rsp    = i_dbl_val & o_dbl_rdy;
    assign add_rsp    = i_add_val & o_add_rdy;
    assign dbl_done   = ~need_dbl | got_dbl | dbl_rsp;
    assign add_done   = ~need_add | got_add | add_rsp;
    assign round_done = dbl_done & add_done;

    assign o_rdy     = (state == ST_IDLE);
    assign o_val     = (state == ST_DONE);
    assign o_p       = o_val ? r_q : INF;
    assign o_dbl_val = dbl_req;
    assign o_dbl_p   = dbl_req ? p_q : INF;
    assign o_add_val = add_req;
    assign o_add_p1  = add_req ? r_q : INF;
    assign o_add_p2  = add_req ? p_q : INF;

    // P must stay put until the adder has taken its copy
    assign o_dbl_rdy = (state == ST_WAIT) & need_dbl & ~got_dbl
                     & ~dbl_req & ~add_req;
    assign o_add_rdy = (state == ST_WAIT) & need_add & ~got_add
                     & ~add_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:  if (i_val) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (issue_stop || !(issue_add || issue_dbl))
                    state_d = ST_DONE;
                else
                    state_d = ST_WAIT;
            end
            ST_WAIT:  if (round_done) state_d = ST_ISSUE;
            ST_DONE:  if (i_rdy) state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            k_q      <= '0;
            p_q      <= INF;
            r_q      <= INF;
            need_dbl <= 1'b0;
            need_add <= 1'b0;
            got_dbl  <= 1'b0;
            got_add  <= 1'b0;
            dbl_req  <= 1'b0;
            add_req  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_val) begin
                        k_q <= i_k;
                        p_q <= i_p;
                        r_q <= INF;
                    end
                end
                ST_ISSUE: begin
                    if (!issue_stop) begin
                        if (k_q[0] && is_inf(r_q)) r_q <= p_q;
                        need_dbl <= issue_dbl;
                        need_add <= issue_add;
                        dbl_req  <= issue_dbl;
                        add_req  <= issue_add;
                        if (!(issue_add || issue_dbl)) k_q <= k_next;
                    end
                end
                ST_WAIT: begin
                    if (dbl_req && i_dbl_rdy) dbl_req <= 1'b0;
                    if (add_req && i_add_rdy) add_req <= 1'b0;
                    if (dbl_rsp) begin
                        p_q     <= i_dbl_p;
                        got_dbl <= 1'b1;
                    end
                    if (add_rsp) begin
                        r_q     <= i_add_p;
                        got_add <= 1'b1;
                    end
                    if (round_done) begin
                        k_q      <= k_next;
                        need_dbl <= 1'b0;
                        need_add <= 1'b0;
                        got_dbl  <= 1'b0;
                        got_add  <= 1'b0;
                    end
                end
                ST_DONE: ;
            endcase
        end
    end

endmodule
